// File: rtl/histogram_cdf_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : histo_pkg
//  Description : Shared defaults, derived widths and FSM state type for the
//                histogram CDF / equalization LUT generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package histo_pkg;

    localparam int BINS     = 256;
    localparam int BIN_W    = 16;
    localparam int PIX_LOG2 = 14;
    localparam int OUT_W    = 8;

    // One extra bit so a full image (exactly 2^PIX_LOG2 pixels) fits.
    localparam int CDF_W    = PIX_LOG2 + 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        ACC  = 3'd2,
        EMIT = 3'd3,
        DONE = 3'd4
    } cdf_state_t;

endpackage
`default_nettype wire

// File: rtl/histogram_cdf_unit_lut_scale.sv
`default_nettype none
// ============================================================================
//  Module      : lut_scale
//  Description : Maps a cumulative pixel count onto an output level:
//                floor(cdf * (2^OUT_W-1) / 2^PIX_LOG2), clamped to full scale.
//  Revision    : 1.0 - initial release
// ============================================================================
module lut_scale #(
    parameter int CDF_W    = histo_pkg::CDF_W,
    parameter int OUT_W    = histo_pkg::OUT_W,
    parameter int PIX_LOG2 = histo_pkg::PIX_LOG2
) (
    input  logic [CDF_W-1:0] i_cdf,
    output logic [OUT_W-1:0] o_level
);

    localparam int               c_PROD_W = CDF_W + OUT_W;
    localparam logic [OUT_W-1:0] c_MAX    = '1;

    logic [c_PROD_W-1:0] w_prod;
    logic [c_PROD_W-1:0] w_shift;

    // Full-width product, floor-divide by the pixel count, then clamp; the
    // clamp only engages when the cdf exceeds a full image (corrupt input).
    always_comb begin
        w_prod  = c_PROD_W'(i_cdf) * c_PROD_W'(c_MAX);
        w_shift = w_prod >> PIX_LOG2;
        o_level = (w_shift > c_PROD_W'(c_MAX)) ? c_MAX : w_shift[OUT_W-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/histogram_cdf_unit.sv
`default_nettype none
// ============================================================================
//  Module      : histogram_cdf_unit
//  Description : Walks the 256 histogram bins, accumulates a saturating CDF
//                and streams the scaled equalization LUT over valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module histogram_cdf_unit
    import histo_pkg::*;
#(
    parameter int BINS     = histo_pkg::BINS,
    parameter int BIN_W    = histo_pkg::BIN_W,
    parameter int PIX_LOG2 = histo_pkg::PIX_LOG2,
    parameter int OUT_W    = histo_pkg::OUT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic [$clog2(BINS)-1:0]  bin_addr,
    input  logic [BIN_W-1:0]         bin_data,
    output logic                     lut_valid,
    input  logic                     lut_ready,
    output logic [$clog2(BINS)-1:0]  lut_addr,
    output logic [OUT_W-1:0]         lut_data,
    output logic                     busy,
    output logic                     done
);

    localparam int c_AW    = $clog2(BINS);
    localparam int c_CDF_W = PIX_LOG2 + 1;
    // Sum must hold the larger operand plus a carry so saturation is exact.
    localparam int c_SUM_W = ((c_CDF_W > BIN_W) ? c_CDF_W : BIN_W) + 1;

    localparam logic [c_CDF_W-1:0] c_CDF_ONES = '1;
    localparam logic [c_AW-1:0]    c_LAST     = c_AW'(BINS - 1);

    cdf_state_t          r_state;
    cdf_state_t          w_state_nxt;
    logic [c_AW-1:0]     r_addr;
    logic [c_CDF_W-1:0]  r_cdf;
    logic [c_SUM_W-1:0]  w_sum;
    logic [c_CDF_W-1:0]  w_cdf_nxt;
    logic [OUT_W-1:0]    w_level;
    logic                r_lut_valid;
    logic [c_AW-1:0]     r_lut_addr;
    logic [OUT_W-1:0]    r_lut_data;
    logic                w_handshake;
    logic                w_last;

    assign bin_addr    = r_addr;
    assign lut_valid   = r_lut_valid;
    assign lut_addr    = r_lut_addr;
    assign lut_data    = r_lut_data;
    assign w_handshake = r_lut_valid & lut_ready;
    assign w_last      = (r_addr == c_LAST);

    // Saturating CDF accumulation of the bin word returned by the memory.
    always_comb begin
        w_sum     = c_SUM_W'(r_cdf) + c_SUM_W'(bin_data);
        w_cdf_nxt = (w_sum > c_SUM_W'(c_CDF_ONES)) ? c_CDF_ONES
                                                   : w_sum[c_CDF_W-1:0];
    end

    lut_scale #(
        .CDF_W    (c_CDF_W),
        .OUT_W    (OUT_W),
        .PIX_LOG2 (PIX_LOG2)
    ) u_lut_scale (
        .i_cdf    (w_cdf_nxt),
        .o_level  (w_level)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus the status outputs derived from the state.
    always_comb begin
        w_state_nxt = r_state;
        busy        = (r_state != IDLE);
        done        = 1'b0;
        case (r_state)
            IDLE: if (start) w_state_nxt = RD;
            RD:   w_state_nxt = ACC;
            ACC:  w_state_nxt = EMIT;
            EMIT: if (w_handshake) w_state_nxt = w_last ? DONE : RD;
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Address counter, CDF register and the registered LUT output port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr      <= '0;
            r_cdf       <= '0;
            r_lut_valid <= 1'b0;
            r_lut_addr  <= '0;
            r_lut_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_addr <= '0;
                        r_cdf  <= '0;
                    end
                end
                ACC: begin
                    r_cdf       <= w_cdf_nxt;
                    r_lut_data  <= w_level;
                    r_lut_addr  <= r_addr;
                    r_lut_valid <= 1'b1;
                end
                EMIT: begin
                    if (w_handshake) begin
                        r_lut_valid <= 1'b0;
                        if (!w_last) r_addr <= r_addr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_histogram_cdf_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_histogram_cdf_unit
//  Description : Self-checking bench for histogram_cdf_unit with a histogram
//                memory model and an arithmetic reference for the LUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_histogram_cdf_unit;

    localparam int c_P    = 10;
    localparam int c_BINS = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  bin_addr;
    logic [15:0] bin_data;
    logic        lut_valid;
    logic        lut_ready;
    logic [7:0]  lut_addr;
    logic [7:0]  lut_data;
    logic        busy;
    logic        done;

    histogram_cdf_unit dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bin_addr  (bin_addr),
        .bin_data  (bin_data),
        .lut_valid (lut_valid),
        .lut_ready (lut_ready),
        .lut_addr  (lut_addr),
        .lut_data  (lut_data),
        .busy      (busy),
        .done      (done)
    );

    always #(c_P/2) clk = ~clk;

    // Histogram memory with a one-cycle synchronous read.
    logic [15:0] mem [c_BINS];
    always @(posedge clk) bin_data <= mem[bin_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: running pixel count clamped to 32767, then level =
    // floor(count*255/16384) clamped to 255.
    int exp_lut [c_BINS];
    int obs_lut [c_BINS];
    function automatic void compute_expected();
        longint cdf = 0;
        longint lvl;
        for (int i = 0; i < c_BINS; i++) begin
            cdf += mem[i];
            if (cdf > 32767) cdf = 32767;
            lvl = (cdf * 255) / 16384;
            if (lvl > 255) lvl = 255;
            exp_lut[i] = int'(lvl);
        end
    endfunction

    task automatic fill_const(input int v);
        for (int i = 0; i < c_BINS; i++) mem[i] = 16'(v);
    endtask

    // Random histogram of a full 128x128 image, biased into a random window.
    task automatic fill_random();
        int lo = $urandom_range(0, 200);
        int hi = $urandom_range(lo + 10, 255);
        fill_const(0);
        for (int p = 0; p < 16384; p++) begin
            int b = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255)
                                                : $urandom_range(lo, hi);
            mem[b] = mem[b] + 16'd1;
        end
    endtask

    // Monitor: scoreboard of accepted entries, stall stability, done pulses.
    int   exp_idx = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   first_valid_cyc = -1;
    bit   prev_stall = 1'b0;
    logic [7:0] prev_addr, prev_data;
    int   rdy_mode = 0;

    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", lut_valid, 1);
                chk("hold_addr", lut_addr, prev_addr);
                chk("hold_data", lut_data, prev_data);
            end
            if (lut_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (lut_valid === 1'b1 && lut_ready === 1'b1) begin
                if (exp_idx < c_BINS) begin
                    chk($sformatf("lut_addr[%0d]", exp_idx), lut_addr, exp_idx);
                    chk($sformatf("lut_data[%0d]", exp_idx), lut_data, exp_lut[exp_idx]);
                    obs_lut[exp_idx] = int'(lut_data);
                end else begin
                    chk("entry_overrun", exp_idx, c_BINS - 1);
                end
                exp_idx++;
            end
            prev_stall = (lut_valid === 1'b1) && (lut_ready !== 1'b1);
            prev_addr  = lut_addr;
            prev_data  = lut_data;
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // Ready driver: random acceptance in mode 1, otherwise left to the test.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 1) lut_ready = ($urandom_range(0, 3) != 0);
        end
    end

    int s0;

    task automatic begin_pass(input int mode);
        compute_expected();
        exp_idx         = 0;
        done_cnt        = 0;
        first_valid_cyc = -1;
        rdy_mode        = mode;
        if (mode == 0) lut_ready = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        s0 = cyc;
    endtask

    task automatic finish_pass(input string name);
        bit seen = 1'b0;
        for (int k = 0; k < 5000 && !seen; k++) begin
            @(posedge clk); #2;
            if (done_cnt > 0) seen = 1'b1;
        end
        chk({name, "_done_seen"}, seen, 1);
        repeat (6) @(posedge clk);
        #2;
        chk({name, "_entries"}, exp_idx, c_BINS);
        chk({name, "_done_cnt"}, done_cnt, 1);
        chk({name, "_busy_idle"}, busy, 0);
    endtask

    task automatic wait_entry(input int a);
        bit found = 1'b0;
        for (int k = 0; k < 3000 && !found; k++) begin
            @(negedge clk);
            if (lut_valid === 1'b1 && lut_addr == 8'(a)) found = 1'b1;
        end
        chk($sformatf("reach_addr_%0d", a), found, 1);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_bin_addr"}, bin_addr, 0);
        chk({tag, "_lut_valid"}, lut_valid, 0);
        chk({tag, "_lut_addr"}, lut_addr, 0);
        chk({tag, "_lut_data"}, lut_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    initial begin
        #(c_P * 100000);
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t_r;
        reset     = 1'b0;
        start     = 1'b0;
        lut_ready = 1'b0;
        fill_const(0);
        #3;
        chk_outputs_zero("reset");
        #(2 * c_P);
        @(negedge clk) reset = 1'b1;

        // Uniform histogram: timing and known LUT points.
        fill_const(64);
        begin_pass(0);
        @(negedge clk);
        chk("uni_busy", busy, 1);
        finish_pass("uniform");
        chk("uni_first_valid_edge", first_valid_cyc - s0, 2);
        chk("uni_done_edge", done_cyc - s0, 3 * c_BINS);
        chk("uni_lut0", obs_lut[0], 0);
        chk("uni_lut127", obs_lut[127], 127);
        chk("uni_lut255", obs_lut[255], 255);

        // All pixels in bin 0 with random backpressure.
        fill_const(0);
        mem[0] = 16'd16384;
        begin_pass(1);
        finish_pass("bin0");
        chk("bin0_lut200", obs_lut[200], 255);

        // Directed backpressure on entry 10.
        fill_random();
        begin_pass(0);
        wait_entry(9);
        @(posedge clk); #1 lut_ready = 1'b0;
        wait_entry(10);
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", lut_valid, 1);
            chk("bp_addr", lut_addr, 10);
            chk("bp_data", lut_data, exp_lut[10]);
        end
        @(posedge clk); #1 lut_ready = 1'b1;
        @(negedge clk);
        t_r = cyc;
        wait_entry(11);
        chk("bp_gap", cyc - t_r, 3);
        finish_pass("backpressure");

        // Reset mid-pass at entry 100, then a fresh pass from bin 0.
        fill_random();
        begin_pass(1);
        wait_entry(100);
        #1 reset = 1'b0;
        #1;
        chk_outputs_zero("midreset");
        @(negedge clk);
        chk_outputs_zero("midreset_held");
        #3 reset = 1'b1;
        fill_random();
        mem[0] = 16'($urandom_range(1, 3000));
        begin_pass(1);
        finish_pass("after_reset");

        // Corrupt histogram: CDF saturation, no wrap.
        fill_const(16'hFFFF);
        begin_pass(1);
        finish_pass("corrupt");
        chk("corrupt_lut0", obs_lut[0], 255);
        chk("corrupt_lut255", obs_lut[255], 255);

        // start pulsed mid-pass is ignored.
        fill_random();
        begin_pass(1);
        wait_entry(50);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        finish_pass("start_mid");
        repeat (10) @(posedge clk);
        #2;
        chk("start_mid_no_restart", busy, 0);
        chk("start_mid_done_once", done_cnt, 1);

        // A couple of further random histograms.
        for (int r = 0; r < 2; r++) begin
            fill_random();
            begin_pass(1);
            finish_pass($sformatf("random%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
